ajuste_relogio: RTL

Time-setting front end for the BCD `relogio` clock. It debounces two raw push-buttons (mode, increment) and runs a field-editing state machine over hours and minutes. It drives the clock's `H_in1/H_in0/M_in1/M_in0` load bus and issues a single-cycle `LD_time` strobe when the user confirms. It sits directly upstream of `relogio` and runs on the same clock.

---
 rtl/ajuste_pkg.sv | 34 +++
 rtl/debounce_btn.sv | 53 +++++
 rtl/ajuste_relogio.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ajuste_pkg.sv
// Shared state type, BCD limits and digit helpers for the ajuste_relogio time-setting front end.
package ajuste_pkg;

    localparam int unsigned BCD_W = 4;

    localparam logic [7:0] HOUR_MAX_BCD = 8'h23;
    localparam logic [7:0] MIN_MAX_BCD  = 8'h59;

    typedef enum logic [1:0] {
        IDLE,
        EDIT_H,
        EDIT_M,
        LOAD
    } state_e;

    // Two-digit BCD increment that wraps to 00 after max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
        logic [7:0] res;
        if (val == max) begin
            res = 8'h00;
        end else if (val[3:0] == 4'd9) begin
            res = {val[7:4] + 4'd1, 4'd0};
        end else begin
            res = {val[7:4], val[3:0] + 4'd1};
        end
        return res;
    endfunction

    // With the low digit <= 9, val <= max also rejects a bad high digit.
    function automatic logic bcd_valid(input logic [7:0] val, input logic [7:0] max);
        return (val[3:0] <= 4'd9) && (val <= max);
    endfunction

endpackage

// File: rtl/debounce_btn.sv
// Button conditioner: 2-flop synchronizer, stability counter and a one-cycle press pulse.
module debounce_btn #(
    parameter int unsigned DEBOUNCE_CYCLES = 20
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync1_q, sync2_q;
    logic            stable_q, stable_d;
    logic            stable_prev_q;
    logic            press_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            press_q       <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= btn_i;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            press_q       <= stable_q & ~stable_prev_q;
            cnt_q         <= cnt_d;
        end
    end

    assign level_o = stable_q;
    assign press_o = press_q;

endmodule

// File: rtl/ajuste_relogio.sv
// Time-setting front end for the relogio clock: debounced buttons drive an hour/minute editor.
// Define AJUSTE_AUTOREPEAT_EN to add hold-to-repeat on the increment button.
module ajuste_relogio
    import ajuste_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 20,
    parameter int unsigned TIMEOUT_CYCLES  = 1000,
    parameter int unsigned HOLD_CYCLES     = 200,
    parameter int unsigned REPEAT_CYCLES   = 50
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             btn_mode_i,
    input  logic             btn_inc_i,
    input  logic [1:0]       cur_h1_i,
    input  logic [BCD_W-1:0] cur_h0_i,
    input  logic [BCD_W-1:0] cur_m1_i,
    input  logic [BCD_W-1:0] cur_m0_i,
    output logic [1:0]       h_in1_o,
    output logic [BCD_W-1:0] h_in0_o,
    output logic [BCD_W-1:0] m_in1_o,
    output logic [BCD_W-1:0] m_in0_o,
    output logic             ld_time_o,
    output logic             edit_active_o,
    output logic             edit_field_o
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    state_e          state_q, state_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [5:0]      hour_q, hour_d;
    logic [7:0]      min_q, min_d;
    logic            ld_q;

    logic mode_ev, inc_press, inc_ev;
    logic mode_level, inc_level;
    logic editing;

    debounce_btn #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_mode (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .btn_i   (btn_mode_i),
        .level_o (mode_level),
        .press_o (mode_ev)
    );

    debounce_btn #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_inc (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .btn_i   (btn_inc_i),
        .level_o (inc_level),
        .press_o (inc_press)
    );

    assign editing = (state_q == EDIT_H) || (state_q == EDIT_M);

`ifdef AJUSTE_AUTOREPEAT_EN
    localparam int unsigned RepMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned RepW   = $clog2(RepMax + 1);

    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
    logic            rep_phase_q, rep_phase_d;
    logic            rep_ev;
    logic            unused_lvl;

    assign unused_lvl = mode_level;

    // First extra event after HOLD_CYCLES of steady press, then one every REPEAT_CYCLES.
    always_comb begin
        rep_cnt_d   = '0;
        rep_phase_d = 1'b0;
        rep_ev      = 1'b0;
        if (inc_level && editing) begin
            rep_phase_d = rep_phase_q;
            if (!rep_phase_q && rep_cnt_q == RepW'(HOLD_CYCLES - 1)) begin
                rep_ev      = 1'b1;
                rep_phase_d = 1'b1;
            end else if (rep_phase_q && rep_cnt_q == RepW'(REPEAT_CYCLES - 1)) begin
                rep_ev = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
        end
    end

    assign inc_ev = inc_press | rep_ev;
`else
    localparam int unsigned UnusedRepCfg = HOLD_CYCLES + REPEAT_CYCLES;
    logic unused_lvl;

    assign unused_lvl = ^{mode_level, inc_level};
    assign inc_ev     = inc_press;
`endif

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        hour_d  = hour_q;
        min_d   = min_q;
        unique case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (mode_ev) begin
                    state_d = EDIT_H;
                    hour_d  = bcd_valid({2'b00, cur_h1_i, cur_h0_i}, HOUR_MAX_BCD) ?
                              {cur_h1_i, cur_h0_i} : 6'h00;
                    min_d   = bcd_valid({cur_m1_i, cur_m0_i}, MIN_MAX_BCD) ?
                              {cur_m1_i, cur_m0_i} : 8'h00;
                end
            end
            EDIT_H, EDIT_M: begin
                // Mode has priority; a coincident inc event is dropped.
                if (mode_ev) begin
                    state_d = (state_q == EDIT_H) ? EDIT_M : LOAD;
                    tmo_d   = '0;
                end else if (inc_ev) begin
                    tmo_d = '0;
                    if (state_q == EDIT_H) begin
                        hour_d = 6'(bcd_inc({2'b00, hour_q}, HOUR_MAX_BCD));
                    end else begin
                        min_d = bcd_inc(min_q, MIN_MAX_BCD);
                    end
                end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            LOAD: begin
                state_d = IDLE;
                tmo_d   = '0;
            end
            default: begin
                state_d = IDLE;
                tmo_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            hour_q  <= '0;
            min_q   <= '0;
            ld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            ld_q    <= (state_d == LOAD);
        end
    end

    assign h_in1_o       = hour_q[5:4];
    assign h_in0_o       = hour_q[3:0];
    assign m_in1_o       = min_q[7:4];
    assign m_in0_o       = min_q[3:0];
    assign ld_time_o     = ld_q;
    assign edit_active_o = editing;
    assign edit_field_o  = (state_q == EDIT_M);

endmodule
